// File: rtl/hdmi_link_pkg.sv
// Shared types and constants for the TMDS serializer link controller.
package hdmi_link_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RESET  = 2'd1,
        SETTLE = 2'd2,
        LIVE   = 2'd3
    } link_state_t;

    // TMDS control symbols (C1C0 = 00, 01, 10, 11)
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Larger of two integers, used to size the shared countdown counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serializer_link_ctrl_sync_2ff.sv
// One-bit, two-flop synchronizer with synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic stage1_reg;
    logic stage2_reg;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage1_reg <= 1'b0;
            stage2_reg <= 1'b0;
        end else begin
            stage1_reg <= d;
            stage2_reg <= stage1_reg;
        end
    end

    assign q = stage2_reg;

endmodule

// File: rtl/serializer_link_ctrl.sv
// Bring-up / run-time controller for the TMDS serializer: holds the
// serializer in reset until lock+enable, sends a control-symbol preamble,
// then passes encoder symbols through, substituting idle symbols on underflow.
module serializer_link_ctrl
    import hdmi_link_pkg::*;
#(
    parameter int NUM_CHANNELS  = 3,
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                         clk_pixel,
    input  logic                         reset_n,
    input  logic                         pll_locked,
    input  logic                         enable,
    input  logic [NUM_CHANNELS-1:0][9:0] tmds_in,
    input  logic                         tmds_in_valid,
    output logic [NUM_CHANNELS-1:0][9:0] tmds_internal,
    output logic                         serializer_reset,
    output logic                         link_up,
    output logic [1:0]                   state,
    output logic [15:0]                  underflow_count
);

    localparam int CNT_LOG = $clog2(max2(RESET_CYCLES, SETTLE_CYCLES));
    localparam int CNT_W   = (CNT_LOG < 1) ? 1 : CNT_LOG;

    logic              locked_s;
    logic              run;
    link_state_t       state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [15:0]       underflow_reg;
    logic              pass_data;

    sync_2ff u_lock_sync (
        .clk     (clk_pixel),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign run = enable && locked_s;

    // Link state machine with shared countdown; losing run always wins and drops to OFF.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
        end else if (!run) begin
            state_reg <= OFF;
            cnt_reg   <= CNT_W'(RESET_CYCLES - 1);
        end else begin
            case (state_reg)
                OFF: begin
                    state_reg <= RESET;
                    cnt_reg   <= CNT_W'(RESET_CYCLES - 1);
                end
                RESET: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SETTLE;
                        cnt_reg   <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= LIVE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= LIVE;
            endcase
        end
    end

    // Data only flows while LIVE and still running, so a dropped run idles the output at the same edge.
    assign pass_data = (state_reg == LIVE) && run && tmds_in_valid;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            // Per-channel output register: encoder symbol or idle control symbol.
            always_ff @(posedge clk_pixel) begin
                if (!reset_n) begin
                    tmds_internal[gi] <= CTRL_00;
                end else if (pass_data) begin
                    tmds_internal[gi] <= tmds_in[gi];
                end else begin
                    tmds_internal[gi] <= CTRL_00;
                end
            end
        end
    endgenerate

    // Saturating count of LIVE cycles that had no valid encoder symbol.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            underflow_reg <= '0;
        end else if ((state_reg == LIVE) && !tmds_in_valid && (underflow_reg != 16'hFFFF)) begin
            underflow_reg <= underflow_reg + 16'd1;
        end
    end

    assign underflow_count  = underflow_reg;
    assign state            = state_reg;
    assign serializer_reset = (state_reg == OFF) || (state_reg == RESET);
    assign link_up          = (state_reg == LIVE);

endmodule

// File: tb/tb_serializer_link_ctrl.sv
// Self-checking bench for serializer_link_ctrl with short countdowns.
module tb_serializer_link_ctrl;

    localparam int NCH = 3;
    localparam int RC  = 4;
    localparam int SC  = 8;
    localparam logic [9:0] CTRL = 10'b1101010100;

    logic                clk_pixel = 1'b0;
    logic                reset_n;
    logic                pll_locked;
    logic                enable;
    logic [NCH-1:0][9:0] tmds_in;
    logic                tmds_in_valid;
    logic [NCH-1:0][9:0] tmds_internal;
    logic                serializer_reset;
    logic                link_up;
    logic [1:0]          state;
    logic [15:0]         underflow_count;

    int total = 0;
    int bad   = 0;
    logic [29:0] exp_q[$];

    serializer_link_ctrl #(
        .NUM_CHANNELS  (NCH),
        .RESET_CYCLES  (RC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk_pixel        (clk_pixel),
        .reset_n          (reset_n),
        .pll_locked       (pll_locked),
        .enable           (enable),
        .tmds_in          (tmds_in),
        .tmds_in_valid    (tmds_in_valid),
        .tmds_internal    (tmds_internal),
        .serializer_reset (serializer_reset),
        .link_up          (link_up),
        .state            (state),
        .underflow_count  (underflow_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Drive one symbol set, push what the serializer should see, then compare after the edge.
    task automatic drive_and_check(input string tag, input logic [9:0] v, input logic valid,
                                   input logic [29:0] exp);
        tmds_in       = {NCH{v}};
        tmds_in_valid = valid;
        exp_q.push_back(exp);
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            logic [29:0] e;
            e = exp_q.pop_front();
            check(tag, {2'b00, tmds_internal}, {2'b00, e});
            $display("txn %s in=%0h valid=%0b out=%0h state=%0d uf=%0d", tag, v, valid,
                     tmds_internal, state, underflow_count);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_sreset"}, 32'(serializer_reset), 32'd1);
        check({tag, "_linkup"}, 32'(link_up), 32'd0);
        check({tag, "_tmds"}, {2'b00, tmds_internal}, {2'b00, {NCH{CTRL}}});
        check({tag, "_uf"}, 32'(underflow_count), 32'd0);
    endtask

    // Enter RESET at the next edge, then walk RESET and SETTLE to LIVE with valid data offered throughout.
    task automatic startup(input string tag);
        enable        = 1'b1;
        tmds_in_valid = 1'b1;
        tmds_in       = {NCH{10'h2AA}};
        tick();
        check({tag, "_rst0"}, 32'(state), 32'd1);
        check({tag, "_rst0_sr"}, 32'(serializer_reset), 32'd1);
        for (int i = 1; i < RC; i++) begin
            tick();
            check({tag, "_rst"}, 32'(state), 32'd1);
        end
        tick();
        check({tag, "_settle0"}, 32'(state), 32'd2);
        check({tag, "_settle0_sr"}, 32'(serializer_reset), 32'd0);
        for (int i = 1; i < SC; i++) begin
            drive_and_check({tag, "_settle_data"}, 10'h2AA, 1'b1, {NCH{CTRL}});
            check({tag, "_settle"}, 32'(state), 32'd2);
            check({tag, "_settle_lu"}, 32'(link_up), 32'd0);
        end
        drive_and_check({tag, "_to_live"}, 10'h2AA, 1'b1, {NCH{CTRL}});
        check({tag, "_live"}, 32'(state), 32'd3);
        check({tag, "_live_lu"}, 32'(link_up), 32'd1);
        check({tag, "_live_sr"}, 32'(serializer_reset), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        pll_locked    = 1'b1;
        enable        = 1'b0;
        tmds_in       = '0;
        tmds_in_valid = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");

        // Release reset; lock propagates through the synchronizer while enable is low.
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_off", 32'(state), 32'd0);

        // Nominal start-up
        startup("nominal");

        // Pass-through ramp
        for (int k = 1; k <= 16; k++) begin
            drive_and_check("ramp", 10'(k), 1'b1, {NCH{10'(k)}});
        end
        check("ramp_uf", 32'(underflow_count), 32'd0);

        // Underflow burst of 5
        for (int k = 0; k < 5; k++) begin
            drive_and_check("underflow", 10'h155, 1'b0, {NCH{CTRL}});
        end
        check("uf_5", 32'(underflow_count), 32'd5);
        drive_and_check("resume", 10'h0F0, 1'b1, {NCH{10'h0F0}});
        check("uf_hold", 32'(underflow_count), 32'd5);

        // Run the counter up to saturation.
        tmds_in_valid = 1'b0;
        repeat (65534 - 5) tick();
        check("uf_fffe", 32'(underflow_count), 32'hFFFE);
        tick();
        check("uf_ffff", 32'(underflow_count), 32'hFFFF);
        repeat (3) tick();
        check("uf_sat", 32'(underflow_count), 32'hFFFF);

        // Reset mid-LIVE
        tmds_in_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        check_reset_values("midlive_reset");
        reset_n = 1'b1;
        enable  = 1'b0;
        repeat (3) tick();

        // Enable low during RESET
        enable = 1'b1;
        tick();
        check("en_rst", 32'(state), 32'd1);
        tick();
        check("en_rst2", 32'(state), 32'd1);
        enable = 1'b0;
        tick();
        check("en_drop_off", 32'(state), 32'd0);
        for (int i = 0; i < RC + SC + 2; i++) begin
            tick();
            check("en_stay_off", 32'(state), 32'd0);
        end

        // Lock loss mid-SETTLE
        enable = 1'b1;
        tick();
        for (int i = 0; i < RC; i++) tick();
        check("ll_settle", 32'(state), 32'd2);
        repeat (2) tick();
        pll_locked = 1'b0;
        tick();
        check("ll_e1", 32'(state), 32'd2);
        tick();
        check("ll_e2", 32'(state), 32'd2);
        tick();
        check("ll_e3_off", 32'(state), 32'd0);
        check("ll_e3_sr", 32'(serializer_reset), 32'd1);

        // Restore lock: two synchronizer edges then a full RESET.
        pll_locked = 1'b1;
        tick();
        check("rl_e1", 32'(state), 32'd0);
        tick();
        check("rl_e2", 32'(state), 32'd0);
        tick();
        check("rl_rst0", 32'(state), 32'd1);
        for (int i = 1; i < RC; i++) begin
            tick();
            check("rl_rst", 32'(state), 32'd1);
        end
        tick();
        check("rl_settle", 32'(state), 32'd2);

        // Full restart to LIVE, then drop enable with valid data pending.
        enable = 1'b0;
        tick();
        check("rs_off", 32'(state), 32'd0);
        startup("restart");
        drive_and_check("rs_data", 10'h1C3, 1'b1, {NCH{10'h1C3}});
        enable = 1'b0;
        drive_and_check("rs_drop", 10'h155, 1'b1, {NCH{CTRL}});
        check("rs_drop_state", 32'(state), 32'd0);
        check("rs_drop_sr", 32'(serializer_reset), 32'd1);
        check("rs_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serializer_link_ctrl.md
# serializer_link_ctrl

Bring-up and run-time controller for the TMDS serializer on the pixel clock. It holds the serializer in reset until the pixel PLL is locked and the link is enabled. It then drives a fixed control-symbol preamble for a settle period, then passes encoder symbols through. Whenever the encoder has nothing valid, it substitutes idle control symbols and counts the underflow. It sits between the TMDS encoders and the serializer, driving the serializer's `reset` and `tmds_internal` inputs.

## Interface
- `NUM_CHANNELS`, 3: number of TMDS data channels.
- `RESET_CYCLES`, 16: clk_pixel cycles the serializer reset is held after start; ≥1.
- `SETTLE_CYCLES`, 1024: cycles of idle control symbols before going live; ≥1.
- `clk_pixel` in 1: pixel clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to clk_pixel; synchronized internally.
- `enable` in 1: link enable, synchronous.
- `tmds_in` in [9:0] x NUM_CHANNELS: encoded symbols from the encoders.
- `tmds_in_valid` in 1: `tmds_in` is valid this cycle.
- `tmds_internal` out [9:0] x NUM_CHANNELS: symbols to the serializer; registered.
- `serializer_reset` out 1: active-high reset to the serializer.
- `link_up` out 1: high in LIVE.
- `state` out 2: current state encoding (OFF=0, RESET=1, SETTLE=2, LIVE=3).
- `underflow_count` out 16: saturating count of LIVE cycles without a valid input.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset value 0) to give `locked_s`.
- Define `run = enable && locked_s`. If `run` is low in any state, the next state is OFF. This has priority over all other transitions.
- **OFF**:
  - `serializer_reset`=1.
  - Go to RESET when `run`=1.
  - Load the counter with RESET_CYCLES-1.
- **RESET**:
  - `serializer_reset`=1.
  - Counter decrements each cycle.
  - At 0, go to SETTLE and load the counter with SETTLE_CYCLES-1.
- **SETTLE**:
  - `serializer_reset`=0.
  - Counter decrements each cycle.
  - At 0, go to LIVE.
- **LIVE**:
  - `serializer_reset`=0 and `link_up`=1.
  - Stays in LIVE until `run` drops.
- Symbol select, registered:
  - If `state`==LIVE and `tmds_in_valid`, then `tmds_internal` ← `tmds_in`.
  - Otherwise every channel ← CTRL_00 = 10'b1101010100.
- Underflow: `underflow_count` increments in cycles where `state`==LIVE and `tmds_in_valid`=0. It saturates at 16'hFFFF and is cleared only by `reset_n`.
- `serializer_reset`, `link_up` and `state` are decoded directly from the state register, so they carry no extra latency.
- Counter width is $clog2(max(RESET_CYCLES, SETTLE_CYCLES)).

## Timing
- Reset values:
  - state OFF, counter 0, synchronizer flops 0.
  - `serializer_reset`=1, `link_up`=0.
  - `tmds_internal` = CTRL_00 on all channels.
  - `underflow_count`=0.
- Start-up sequence, with `locked_s` already 1 and `enable` rising before edge 0:
  - RESET is entered at edge 0.
  - SETTLE is entered at edge RESET_CYCLES.
  - LIVE is entered at edge RESET_CYCLES+SETTLE_CYCLES.
- Lock latency: `pll_locked` is sampled at edge t and `locked_s` is high after edge t+1. So RESET starts at edge t+2 (with `enable` high); a falling `pll_locked` forces OFF at the same edge.
- Data path latency: `tmds_in` sampled at edge t appears on `tmds_internal` after edge t. This is 1 cycle; there is no bubble at the SETTLE→LIVE boundary.
- Loss of `run` mid-operation, including inside the RESET or SETTLE countdown: OFF at the next edge. `tmds_internal` reverts to CTRL_00 at that same edge, and the counter value is discarded.
- `run` re-asserting in OFF restarts the full sequence; there is no shortcut to LIVE.
- `tmds_in_valid` is ignored outside LIVE, and no underflow is counted there.

## Structure
- Package `hdmi_link_pkg` holds:
  - the state enum `link_state_t` (OFF, RESET, SETTLE, LIVE);
  - the control-symbol constants CTRL_00/01/10/11.
- Sub-module `sync_2ff`: a 1-bit, 2-flop synchronizer with synchronous active-low reset.
- The top contains:
  - the state register and countdown counter;
  - the per-channel output register, generated over NUM_CHANNELS;
  - the saturating counter.

## Test plan
- **Nominal start-up** (RESET_CYCLES=4, SETTLE_CYCLES=8): assert `reset_n`, hold `pll_locked`=1, raise `enable` → RESET lasts 4 cycles, SETTLE lasts 8 cycles with `tmds_internal`=10'h354 on all channels, then `link_up`=1.
- **Pass-through**: in LIVE, drive a valid ramp 10'h001..10'h010 → `tmds_internal` equals the input 1 cycle later, and `underflow_count` stays 0.
- **Underflow**: in LIVE, drop `tmds_in_valid` for 5 cycles → CTRL_00 is output for those 5 cycles and `underflow_count`=5. Preloading near 16'hFFFF checks that the count saturates.
- **Lock loss mid-SETTLE**: drop `pll_locked` → state OFF and `serializer_reset`=1 within 3 edges. Restoring lock restarts a full RESET of 4 cycles.
- **Reset mid-LIVE**: `reset_n`=0 for 1 cycle → all outputs return to their reset values at the next edge, including `underflow_count`=0.
- **Enable low in RESET**: → OFF at the next edge, and SETTLE is never entered.
